mfp_clock_divider_prog: RTL and testbench
=========================================

// Module: mfp_clock_divider_prog
// PURPOSE
//  Programmable integer clock divider, successor to the power-of-two tap divider.
//  Divides gclk by any N in 2..2^DIV_WIDTH-1, selected from four parameter presets via
//  mode, or from a runtime value loaded by software.
//  Divisor changes are glitch-free: they take effect only at a period boundary.
//  Drives the slow system clock inside mfp_system.
// PARAMETERS
//  DIV_WIDTH  16         width of divisor and internal counter
//  DIV_MODE0  2          divisor preset for mode 2'b00 (also the reset divisor)
//  DIV_MODE1  DIV_MODE0  divisor preset for mode 2'b01
//  DIV_MODE2  DIV_MODE0  divisor preset for mode 2'b10
//  DIV_MODE3  DIV_MODE0  divisor preset for mode 2'b11
// PORTS
//  gclk       in   1          source clock; all logic on posedge
//  reset      in   1          asynchronous, active-high reset
//  mode       in   2          preset select; any change requests that preset
//  div_load   in   1          1-cycle strobe: request divisor div_value
//  div_value  in   DIV_WIDTH  runtime divisor, sampled when div_load=1
//  clk        out  1          divided clock, registered
//  pending    out  1          a divisor request is waiting for the period boundary
//  cur_div    out  DIV_WIDTH  divisor currently in effect (post-clamp)
//  tick       out  1          only with MFP_CLKDIV_TICK_EN; see CONFIGURATION
// BEHAVIOUR
//  Clamp: any requested divisor N<2 (including presets) becomes 2. There is no bypass.
//  Period: N gclk cycles. H = ceil(N/2).
//  - clk=1 for the first H cycles of each period, 0 for the remaining N-H.
//  - N=2: 1/1. N=5: 3 high / 2 low. N=6: 3/3.
//  Counter: cntr runs 0..N-1 and wraps to 0. Cycle with cntr==N-1 is the period boundary.
//  Requests:
//  - A div_load strobe, or mode differing from its value registered on the previous
//    cycle, latches the clamped target into pend_div and sets pending=1 on the next edge.
//  - Newer request overwrites pend_div (latest wins; no queue).
//  - Same-cycle div_load and mode change: div_load wins.
//  - A request equal to cur_div still sets pending; it is applied, with no visible effect.
//  Apply:
//  - At the boundary edge with pending=1: cur_div<=pend_div, pending<=0, cntr<=0.
//  - New period starts with clk=1 under the new divisor.
//  - A request arriving in the boundary cycle itself is applied at the next boundary.
//  - No clk pulse is ever shorter than min(old,new) high/low phase. No runts, no truncation.
//  Reset (async assert, sync to gclk on release):
//  - cur_div=clamp(DIV_MODE0), cntr=cur_div-1, clk=0, pending=0, tick=0.
//  - Mode history register <= mode at reset, so no request fires on release.
//  - First gclk edge after release: cntr->0, clk->1.
//  - Reset mid-period: clk drops to 0 immediately (async); pending request is discarded.
//  Latency: request -> applied within at most N_old+1 gclk cycles; cur_div updates at that edge.
// CONFIGURATION
//  MFP_CLKDIV_TICK_EN defined:
//  - tick is a 1-gclk-cycle pulse, asserted in the cycle where clk is first 1 in each period
//    (cycle with cntr==0).
//  - Usable as a clock enable for gclk-domain logic.
//  MFP_CLKDIV_TICK_EN undefined: tick port and its logic are absent. All else is identical.
// TESTING
//  1 DIV_MODE0=2, reset 5 cycles then release -> clk 0 during reset,
//    1 on 1st edge, toggles every edge.
//  2 mode=01, DIV_MODE1=5 -> pending=1 one edge later;
//    after current period, clk 3 high/2 low repeating; cur_div=5.
//  3 N=8, div_load div_value=3 at cntr=2 -> old period finishes (4 hi/4 lo);
//    then 2 hi/1 lo; no runt pulse.
//  4 div_load div_value=0, then value=1 -> cur_div=2 both times, clk period 2.
//  5 div_load 7 then div_load 9 same period; simultaneous mode change with load ->
//    only 9/loaded value applied.
//  6 reset asserted mid high phase with pending=1 -> clk=0 immediately,
//    pending=0, cur_div=DIV_MODE0; with TICK_EN, tick pulses once per period, at cntr 0.

Source files
------------

// File: rtl/mfp_clock_divider_prog_if.sv
// Control/status bundle for the programmable clock divider.
// The tick signal exists only when MFP_CLKDIV_TICK_EN is defined.
interface mfp_clock_divider_prog_if #(
    parameter int DIV_WIDTH = 16
);
    logic [1:0]           mode;
    logic                 div_load;
    logic [DIV_WIDTH-1:0] div_value;
    logic                 clk;
    logic                 pending;
    logic [DIV_WIDTH-1:0] cur_div;
`ifdef MFP_CLKDIV_TICK_EN
    logic                 tick;

    modport master (output mode, div_load, div_value, input clk, pending, cur_div, tick);
    modport slave  (input mode, div_load, div_value, output clk, pending, cur_div, tick);
`else
    modport master (output mode, div_load, div_value, input clk, pending, cur_div);
    modport slave  (input mode, div_load, div_value, output clk, pending, cur_div);
`endif
endinterface

// File: rtl/mfp_clock_divider_prog.sv
// Programmable integer clock divider, N in 2..2^DIV_WIDTH-1, glitch-free divisor switching.
// Optional MFP_CLKDIV_TICK_EN adds a one-gclk-cycle tick at the start of every period.
module mfp_clock_divider_prog #(
    parameter int DIV_WIDTH = 16,
    parameter int DIV_MODE0 = 2,
    parameter int DIV_MODE1 = DIV_MODE0,
    parameter int DIV_MODE2 = DIV_MODE0,
    parameter int DIV_MODE3 = DIV_MODE0
) (
    input  logic                      gclk,
    input  logic                      reset,
    mfp_clock_divider_prog_if.slave   bus
);
    localparam logic [DIV_WIDTH-1:0] RST_DIV =
        (DIV_MODE0 < 2) ? DIV_WIDTH'(2) : DIV_WIDTH'(DIV_MODE0);

    function automatic logic [DIV_WIDTH-1:0] clamp(input logic [DIV_WIDTH-1:0] v);
        return (v < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : v;
    endfunction

    logic [DIV_WIDTH-1:0] cntr_q, cntr_d;
    logic [DIV_WIDTH-1:0] cur_div_q, cur_div_d;
    logic [DIV_WIDTH-1:0] pend_div_q, pend_div_d;
    logic                 pending_q, pending_d;
    logic                 clk_q, clk_d;
    logic [1:0]           mode_q, mode_d;
    logic                 tick_q, tick_d;

    logic [DIV_WIDTH-1:0] preset;
    logic [DIV_WIDTH-1:0] req_div;
    logic                 req;
    logic                 boundary;
    logic [DIV_WIDTH:0]   half;

    always_comb begin
        preset     = RST_DIV;
        cntr_d     = cntr_q + 1'b1;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pending_d  = pending_q;
        mode_d     = bus.mode;

        case (bus.mode)
            2'b00:   preset = DIV_WIDTH'(DIV_MODE0);
            2'b01:   preset = DIV_WIDTH'(DIV_MODE1);
            2'b10:   preset = DIV_WIDTH'(DIV_MODE2);
            default: preset = DIV_WIDTH'(DIV_MODE3);
        endcase

        req      = bus.div_load || (bus.mode != mode_q);
        req_div  = clamp(bus.div_load ? bus.div_value : preset);
        boundary = (cntr_q == cur_div_q - 1'b1);

        // Divisor swaps only at the wrap, so the old period always completes intact.
        if (boundary) begin
            cntr_d = '0;
            if (pending_q) begin
                cur_div_d = pend_div_q;
                pending_d = 1'b0;
            end
        end

        // Applied after the swap: a request landing in the boundary cycle waits a period.
        if (req) begin
            pend_div_d = req_div;
            pending_d  = 1'b1;
        end

        // High for the first ceil(N/2) cycles; extra bit keeps N+1 from overflowing.
        half   = ({1'b0, cur_div_d} + 1'b1) >> 1;
        clk_d  = ({1'b0, cntr_d} < half);
        tick_d = (cntr_d == '0);
    end

    always_ff @(posedge gclk or posedge reset) begin
        if (reset) begin
            cntr_q     <= RST_DIV - 1'b1;
            cur_div_q  <= RST_DIV;
            pend_div_q <= RST_DIV;
            pending_q  <= 1'b0;
            clk_q      <= 1'b0;
            mode_q     <= bus.mode;
            tick_q     <= 1'b0;
        end else begin
            cntr_q     <= cntr_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            pending_q  <= pending_d;
            clk_q      <= clk_d;
            mode_q     <= mode_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.clk     = clk_q;
    assign bus.pending = pending_q;
    assign bus.cur_div = cur_div_q;
`ifdef MFP_CLKDIV_TICK_EN
    assign bus.tick    = tick_q;
`else
    logic unused_tick;
    assign unused_tick = tick_q;
`endif
endmodule

// File: tb/tb_mfp_clock_divider_prog.sv
// Directed bench for mfp_clock_divider_prog: presets 2/5/8/4, runtime loads, clamp, reset.
module tb_mfp_clock_divider_prog;
    logic gclk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mfp_clock_divider_prog_if #(.DIV_WIDTH(16)) bus ();

    mfp_clock_divider_prog #(
        .DIV_WIDTH(16), .DIV_MODE0(2), .DIV_MODE1(5), .DIV_MODE2(8), .DIV_MODE3(4)
    ) dut (
        .gclk  (gclk),
        .reset (reset),
        .bus   (bus)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the pending request to be applied.
    task automatic wait_apply();
        int n;
        n = 0;
        do begin
            @(negedge gclk);
            n++;
        end while (bus.pending !== 1'b0 && n < 60);
    endtask

    task automatic load(input logic [15:0] v);
        bus.div_load  = 1'b1;
        bus.div_value = v;
        @(negedge gclk);
        bus.div_load  = 1'b0;
    endtask

    initial begin
        logic [9:0]  pat10;
        logic [13:0] pat14;
        logic [8:0]  pat9;
        logic [8:0]  tk9;
        int          n;

        reset = 1'b1;
        bus.mode = 2'b00;
        bus.div_load = 1'b0;
        bus.div_value = '0;

        // 1: reset state, then /2 toggling
        repeat (5) @(negedge gclk);
        chk("rst_clk", bus.clk, 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_cur_div", bus.cur_div, 2);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge gclk);
            chk("t1_clk", bus.clk, (i % 2 == 0) ? 1 : 0);
        end

        // 2: mode 01 -> preset 5
        bus.mode = 2'b01;
        @(negedge gclk);
        chk("t2_pending_set", bus.pending, 1);
        chk("t2_div_old", bus.cur_div, 2);
        @(negedge gclk);
        chk("t2_clk_low", bus.clk, 0);
        @(negedge gclk);
        chk("t2_cur_div", bus.cur_div, 5);
        chk("t2_pending_clr", bus.pending, 0);
        pat10 = '0;
        pat10 = {pat10[8:0], bus.clk};
        for (int i = 1; i < 10; i++) begin
            @(negedge gclk);
            pat10 = {pat10[8:0], bus.clk};
        end
        chk("t2_clk_pattern", pat10, 10'b1110011100);

        // 3: mode 10 -> preset 8, then load 3 at cntr==2
        bus.mode = 2'b10;
        n = 0;
        do begin
            @(negedge gclk);
            n++;
        end while (bus.cur_div !== 16'd8 && n < 60);
        chk("t3_cur_div8", bus.cur_div, 8);
        pat14 = '0;
        pat14 = {pat14[12:0], bus.clk};
        @(negedge gclk);
        pat14 = {pat14[12:0], bus.clk};
        @(negedge gclk);
        pat14 = {pat14[12:0], bus.clk};
        bus.div_load = 1'b1;
        bus.div_value = 16'd3;
        @(negedge gclk);
        bus.div_load = 1'b0;
        pat14 = {pat14[12:0], bus.clk};
        chk("t3_pending", bus.pending, 1);
        for (int i = 4; i < 14; i++) begin
            @(negedge gclk);
            pat14 = {pat14[12:0], bus.clk};
        end
        chk("t3_clk_pattern", pat14, 14'b11110000110110);
        chk("t3_cur_div3", bus.cur_div, 3);

        // 4: clamp of 0 and 1 to 2
        load(16'd0);
        chk("t4a_pending", bus.pending, 1);
        wait_apply();
        chk("t4a_pending_clr", bus.pending, 0);
        chk("t4a_cur_div", bus.cur_div, 2);
        chk("t4a_clk_start", bus.clk, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge gclk);
            chk("t4a_clk", bus.clk, (i % 2 == 0) ? 0 : 1);
        end
        load(16'd1);
        chk("t4b_pending", bus.pending, 1);
        wait_apply();
        chk("t4b_cur_div", bus.cur_div, 2);
        chk("t4b_clk_start", bus.clk, 1);
        @(negedge gclk);
        chk("t4b_clk_low", bus.clk, 0);

        // 5: latest request wins; load beats simultaneous mode change
        load(16'd6);
        wait_apply();
        chk("t5_cur_div6", bus.cur_div, 6);
        bus.div_load = 1'b1;
        bus.div_value = 16'd7;
        @(negedge gclk);
        bus.div_value = 16'd9;
        bus.mode = 2'b11;
        @(negedge gclk);
        bus.div_load = 1'b0;
        wait_apply();
        chk("t5_cur_div9", bus.cur_div, 9);
        pat9 = '0;
        tk9 = '0;
        pat9 = {pat9[7:0], bus.clk};
`ifdef MFP_CLKDIV_TICK_EN
        tk9 = {tk9[7:0], bus.tick};
`endif
        for (int i = 1; i < 9; i++) begin
            @(negedge gclk);
            pat9 = {pat9[7:0], bus.clk};
`ifdef MFP_CLKDIV_TICK_EN
            tk9 = {tk9[7:0], bus.tick};
`endif
        end
        chk("t5_clk_pattern", pat9, 9'b111110000);
`ifdef MFP_CLKDIV_TICK_EN
        chk("t5_tick_pattern", tk9, 9'b100000000);
`endif
        @(negedge gclk);
        chk("t5_no_extra_req", bus.pending, 0);
        chk("t5_cur_div_hold", bus.cur_div, 9);

        // 6: reset mid high phase with a pending request
        load(16'd5);
        chk("t6_pending", bus.pending, 1);
        chk("t6_clk_high", bus.clk, 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_clk", bus.clk, 0);
        chk("t6_async_pending", bus.pending, 0);
        chk("t6_async_cur_div", bus.cur_div, 2);
        repeat (2) @(negedge gclk);
        reset = 1'b0;
        @(negedge gclk);
        chk("t6_rel_clk", bus.clk, 1);
        chk("t6_rel_pending", bus.pending, 0);
        chk("t6_rel_cur_div", bus.cur_div, 2);
`ifdef MFP_CLKDIV_TICK_EN
        chk("t6_rel_tick", bus.tick, 1);
`endif
        @(negedge gclk);
        chk("t6_clk_low", bus.clk, 0);
`ifdef MFP_CLKDIV_TICK_EN
        chk("t6_tick_low", bus.tick, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
